// File: rtl/escalar_seq_ctrl.sv
// Sequential scalar-by-matrix multiplier. Multiplies up to 25 signed 8-bit
// elements by a signed 8-bit scalar with one shared shift-add datapath.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             operation request, sampled only in IDLE
//   matriz_A          25 x int8 input, element i at [i*8+7:i*8]
//   num_inteiro       int8 scalar multiplier
//   matrix_size       00=2x2 01=3x3 10=4x4 11=5x5
//   busy, done        status; done is a one-cycle completion pulse
//   nova_matriz_A     registered result, same packing as matriz_A
//   overflow_flag     sticky overflow of the current/last operation
// Build option: define ESCALAR_SATURACAO_EN to store 8'h7F / 8'h80 on
// overflow instead of the truncated low byte.
module escalar_seq_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [199:0] matriz_A,
  input  logic [7:0]   num_inteiro,
  input  logic [1:0]   matrix_size,
  output logic         busy,
  output logic         done,
  output logic [199:0] nova_matriz_A,
  output logic         overflow_flag
);

  typedef enum logic [2:0] {
    IDLE, LOAD, MULT, WRITE, DONE
  } state_t;

  state_t state, state_nxt;

  logic [199:0]       a_q;
  logic [7:0]         k_q;
  logic [1:0]         sz_q;
  logic signed [15:0] acc;
  logic [4:0]         idx;
  logic [2:0]         bit_cnt;

  logic [4:0]         n_elem;
  logic [7:0]         elem;
  logic signed [15:0] addend;
  logic signed [15:0] acc_nxt;
  logic               ovf_now;
  logic [7:0]         wr_val;
  logic               last;

  always_comb begin
    n_elem = 5'd25;
    unique case (sz_q)
      2'b00:   n_elem = 5'd4;
      2'b01:   n_elem = 5'd9;
      2'b10:   n_elem = 5'd16;
      default: n_elem = 5'd25;
    endcase
  end

  assign elem   = a_q[{idx, 3'b000} +: 8];
  assign addend = $signed({{8{elem[7]}}, elem}) <<< bit_cnt;

  // Bit 7 of the scalar carries weight -128, hence the subtraction.
  always_comb begin
    acc_nxt = acc;
    if (k_q[bit_cnt]) begin
      if (bit_cnt == 3'd7) acc_nxt = acc - addend;
      else                 acc_nxt = acc + addend;
    end
  end

  assign ovf_now = (acc[15:8] != {8{acc[7]}});
  assign last    = ((idx + 5'd1) == n_elem);

`ifdef ESCALAR_SATURACAO_EN
  assign wr_val = ovf_now ? (acc[15] ? 8'h80 : 8'h7F) : acc[7:0];
`else
  assign wr_val = acc[7:0];
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD:  state_nxt = MULT;
      MULT:  if (bit_cnt == 3'd7) state_nxt = WRITE;
      WRITE: state_nxt = last ? DONE : MULT;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q           <= '0;
      k_q           <= '0;
      sz_q          <= '0;
      acc           <= '0;
      idx           <= '0;
      bit_cnt       <= '0;
      nova_matriz_A <= '0;
      overflow_flag <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          a_q           <= matriz_A;
          k_q           <= num_inteiro;
          sz_q          <= matrix_size;
          acc           <= '0;
          idx           <= '0;
          bit_cnt       <= '0;
          nova_matriz_A <= '0;
          overflow_flag <= 1'b0;
        end
        MULT: begin
          acc     <= acc_nxt;
          bit_cnt <= bit_cnt + 3'd1;
        end
        WRITE: begin
          nova_matriz_A[{idx, 3'b000} +: 8] <= wr_val;
          if (ovf_now) overflow_flag <= 1'b1;
          idx     <= idx + 5'd1;
          acc     <= '0;
          bit_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_escalar_seq_ctrl.sv
// Directed self-checking bench for escalar_seq_ctrl.
// Checks reset, 2x2/3x3/4x4/5x5 results, latency, overflow, busy-start.
module tb_escalar_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [199:0] matriz_A;
  logic [7:0]   num_inteiro;
  logic [1:0]   matrix_size;
  logic         busy;
  logic         done;
  logic [199:0] nova_matriz_A;
  logic         overflow_flag;

  int checks = 0;
  int failures = 0;

  escalar_seq_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .matriz_A     (matriz_A),
    .num_inteiro  (num_inteiro),
    .matrix_size  (matrix_size),
    .busy         (busy),
    .done         (done),
    .nova_matriz_A(nova_matriz_A),
    .overflow_flag(overflow_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [199:0] obs,
                     input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation, wait for done, check latency and the pulse.
  // With disturb set, inputs change and start pulses mid-run.
  task automatic run_op(input string tag, input logic [199:0] a,
                        input logic [7:0] s, input logic [1:0] sz,
                        input int exp_lat, input bit disturb);
    int cnt;
    int extra;
    matriz_A    = a;
    num_inteiro = s;
    matrix_size = sz;
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, "_busy"}, 200'(busy), 200'(1));
    cnt = 0;
    while (cnt < 400) begin
      @(posedge clk);
      cnt++;
      #1;
      if (done) break;
      if (disturb) begin
        if (cnt == 5) begin
          start       = 1'b1;
          matriz_A    = {25{8'h7E}};
          num_inteiro = 8'h55;
          matrix_size = 2'b11;
        end
        if (cnt == 6)  start = 1'b0;
        if (cnt == 20) start = 1'b1;
        if (cnt == 21) start = 1'b0;
      end
    end
    chk({tag, "_latency"}, 200'(cnt), 200'(exp_lat));
    @(posedge clk);
    #1;
    chk({tag, "_done_1cyc"}, 200'({busy, done}), 200'(0));
    if (disturb) begin
      extra = 0;
      repeat (60) begin
        @(posedge clk);
        #1;
        if (done || busy) extra++;
      end
      chk({tag, "_no_restart"}, 200'(extra), 200'(0));
    end
  endtask

  logic [199:0] a;
  logic [199:0] exp_v;
  int           cnt;

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    matriz_A    = '0;
    num_inteiro = '0;
    matrix_size = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {busy, done, overflow_flag, nova_matriz_A[196:0]},
        200'(0));
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_start", 200'(busy), 200'(0));

    // 2x2: {1,2,3,4} * 3, unused elements nonzero
    a = {25{8'h11}};
    a[31:0] = 32'h04030201;
    run_op("2x2", a, 8'd3, 2'b00, 37, 1'b0);
    exp_v = '0;
    exp_v[31:0] = 32'h0C090603;
    chk("2x2_result", nova_matriz_A, exp_v);
    chk("2x2_ovf", 200'(overflow_flag), 200'(0));

    // 3x3: all 5 * -2 = -10 = F6
    run_op("3x3", {25{8'h05}}, 8'hFE, 2'b01, 82, 1'b0);
    exp_v = '0;
    exp_v[71:0] = {9{8'hF6}};
    chk("3x3_result", nova_matriz_A, exp_v);
    chk("3x3_ovf", 200'(overflow_flag), 200'(0));

    // 5x5: 64 * 4 = 256 overflows
    run_op("5x5", {25{8'h40}}, 8'd4, 2'b11, 226, 1'b0);
`ifdef ESCALAR_SATURACAO_EN
    exp_v = {25{8'h7F}};
`else
    exp_v = '0;
`endif
    chk("5x5_result", nova_matriz_A, exp_v);
    chk("5x5_ovf", 200'(overflow_flag), 200'(1));

    // Boundary: -128 * -1 = +128, with busy starts and input changes
    a = '0;
    a[7:0] = 8'h80;
    run_op("bnd", a, 8'hFF, 2'b00, 37, 1'b1);
    exp_v = '0;
`ifdef ESCALAR_SATURACAO_EN
    exp_v[7:0] = 8'h7F;
`else
    exp_v[7:0] = 8'h80;
`endif
    chk("bnd_result", nova_matriz_A, exp_v);
    chk("bnd_ovf", 200'(overflow_flag), 200'(1));

    // Scalar 0 with nonzero elements: zero result, full latency
    run_op("zero", {25{8'h93}}, 8'd0, 2'b00, 37, 1'b0);
    chk("zero_result", nova_matriz_A, 200'(0));
    chk("zero_ovf", 200'(overflow_flag), 200'(0));

    // Reset during MULT of element 2 in 4x4 mode
    a = '0;
    for (int i = 0; i < 16; i++) a[i*8 +: 8] = 8'(i + 1);
    matriz_A    = a;
    num_inteiro = 8'hFD;
    matrix_size = 2'b10;
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    chk("rst_pre_partial", 200'(nova_matriz_A[15:0]), 200'(16'hFAFD));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {busy, done, overflow_flag, nova_matriz_A[196:0]},
        200'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (done || busy) cnt++;
    end
    chk("rst_no_done", 200'(cnt), 200'(0));

    run_op("4x4", a, 8'hFD, 2'b10, 145, 1'b0);
    exp_v = '0;
    for (int i = 0; i < 16; i++) exp_v[i*8 +: 8] = 8'(-3 * (i + 1));
    chk("4x4_result", nova_matriz_A, exp_v);
    chk("4x4_ovf", 200'(overflow_flag), 200'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
